// File: rtl/spi_regs_pkg.sv
// spi_regs_pkg: shared register map, CTRL bit positions, command layout and FSM state type
package spi_regs_pkg;
    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_PRESCALE = 3'd1;
    localparam logic [2:0] ADDR_COUNT_LO = 3'd2;
    localparam logic [2:0] ADDR_COUNT_HI = 3'd3;
    localparam logic [2:0] ADDR_LED      = 3'd4;
    localparam logic [2:0] ADDR_STATUS   = 3'd5;
    localparam logic [2:0] ADDR_ID       = 3'd6;
    localparam logic [2:0] ADDR_SCRATCH  = 3'd7;
    localparam int CTRL_EN       = 0;
    localparam int CTRL_DOWN     = 1;
    localparam int CTRL_CLR      = 2;
    localparam int CMD_WRITE_BIT = 7;
    localparam int LED_W         = 5;
    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_WRITE, ST_READ, ST_IGNORE} state_t;
    function automatic logic cmd_ok(input logic [7:0] b);
        return b[6:3] == 4'd0;
    endfunction
endpackage

// File: rtl/spi_cmd_regs_counter_core.sv
// counter_core: free-running base divider, programmable prescaler and 16-bit up/down counter
//   in:  clk, rst, en, down, clr, prescale[7:0], load_lo, load_hi, load_data[7:0]
//   out: count[15:0], ovf_pulse (one cycle, on a counted wrap)
module counter_core #(
    parameter int DIV_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        down,
    input  logic        clr,
    input  logic [7:0]  prescale,
    input  logic        load_lo,
    input  logic        load_hi,
    input  logic [7:0]  load_data,
    output logic [15:0] count,
    output logic        ovf_pulse
);
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       pre_q, pre_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             strobe, tick, load;

    always_comb begin
        strobe = en && (div_q == {DIV_W{1'b1}});
        tick   = strobe && (pre_q == prescale);
        load   = load_lo || load_hi;
        div_d  = en ? div_q + {{(DIV_W-1){1'b0}}, 1'b1} : div_q;
        // a prescale lowered below the running count restarts the prescaler
        pre_d  = (pre_q > prescale) ? 8'd0 : strobe ? (tick ? 8'd0 : pre_q + 8'd1) : pre_q;
        cnt_d  = tick ? (down ? cnt_q - 16'd1 : cnt_q + 16'd1) : cnt_q;
        // a host write to either count byte replaces the tick result
        if (load)
            cnt_d = {load_hi ? load_data : cnt_q[15:8], load_lo ? load_data : cnt_q[7:0]};
        if (clr) begin
            cnt_d = '0;
            pre_d = '0;
            div_d = '0;
        end
        ovf_pulse = tick && !load && !clr && (down ? cnt_q == 16'h0000 : cnt_q == 16'hFFFF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            div_q <= div_d;
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
endmodule

// File: rtl/spi_cmd_regs.sv
// spi_cmd_regs: SPI command/address/data decoder driving an 8-entry register file and counter
//   in:  clk, rst, cs_n, rx_valid, rx_data[7:0]
//   out: tx_data[7:0] (reply for next transfer), leds[4:0], count[15:0]
module spi_cmd_regs
    import spi_regs_pkg::*;
#(
    parameter int         DIV_W    = 16,
    parameter logic [7:0] ID_VALUE = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs_n,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic [7:0]       tx_data,
    output logic [LED_W-1:0] leds,
    output logic [15:0]      count
);
    state_t           state_q, state_d;
    logic [2:0]       addr_q, addr_d, addr_inc, rd_addr;
    logic [7:0]       tx_q, tx_d, rd_data, status;
    logic [7:0]       prescale_q, prescale_d, scratch_q, scratch_d, shadow_q, shadow_d;
    logic [LED_W-1:0] led_q, led_d;
    logic             en_q, en_d, down_q, down_d, ovf_q, ovf_d, cs_prev_q;
    logic             byte_in, cmd_good, cmd_wr, rd_load, wr, clr, load_lo, load_hi, ovf_pulse;

    counter_core #(.DIV_W(DIV_W)) u_core (
        .clk       (clk),
        .rst       (rst),
        .en        (en_q),
        .down      (down_q),
        .clr       (clr),
        .prescale  (prescale_q),
        .load_lo   (load_lo),
        .load_hi   (load_hi),
        .load_data (rx_data),
        .count     (count),
        .ovf_pulse (ovf_pulse)
    );

    always_comb begin
        byte_in  = !cs_n && rx_valid;
        cmd_good = cmd_ok(rx_data);
        cmd_wr   = rx_data[CMD_WRITE_BIT];
        addr_inc = addr_q + 3'd1;
        rd_addr  = (state_q == ST_CMD) ? rx_data[2:0] : addr_inc;
        rd_load  = byte_in && ((state_q == ST_CMD && cmd_good && !cmd_wr) || state_q == ST_READ);
        wr       = byte_in && state_q == ST_WRITE;
        load_lo  = wr && addr_q == ADDR_COUNT_LO;
        load_hi  = wr && addr_q == ADDR_COUNT_HI;
        status   = {7'd0, ovf_q};
    end

    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            ADDR_CTRL:     rd_data = {6'd0, down_q, en_q};
            ADDR_PRESCALE: rd_data = prescale_q;
            ADDR_COUNT_LO: rd_data = count[7:0];
            ADDR_COUNT_HI: rd_data = shadow_q;
            ADDR_LED:      rd_data = {{(8-LED_W){1'b0}}, led_q};
            ADDR_STATUS:   rd_data = status;
            ADDR_ID:       rd_data = ID_VALUE;
            default:       rd_data = scratch_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tx_d    = tx_q;
        if (cs_n) begin
            state_d = ST_IDLE;
            tx_d    = status;
        end else if (state_q == ST_IDLE) begin
            tx_d = status;
            // only a genuine falling edge opens a transaction
            if (cs_prev_q)
                state_d = ST_CMD;
        end else if (rx_valid) begin
            case (state_q)
                ST_CMD: begin
                    if (!cmd_good) begin
                        state_d = ST_IGNORE;
                        tx_d    = 8'hFF;
                    end else begin
                        addr_d  = rx_data[2:0];
                        state_d = cmd_wr ? ST_WRITE : ST_READ;
                        tx_d    = cmd_wr ? 8'h00 : rd_data;
                    end
                end
                ST_WRITE: begin
                    addr_d = addr_inc;
                    tx_d   = 8'h00;
                end
                ST_READ: begin
                    addr_d = addr_inc;
                    tx_d   = rd_data;
                end
                default: tx_d = 8'hFF;
            endcase
        end
    end

    always_comb begin
        en_d       = en_q;
        down_d     = down_q;
        prescale_d = prescale_q;
        led_d      = led_q;
        scratch_d  = scratch_q;
        ovf_d      = ovf_q;
        clr        = 1'b0;
        // the high byte is frozen whenever the low byte is handed to the host
        shadow_d   = (rd_load && rd_addr == ADDR_COUNT_LO) ? count[15:8] : shadow_q;
        if (wr) begin
            case (addr_q)
                ADDR_CTRL: begin
                    en_d   = rx_data[CTRL_EN];
                    down_d = rx_data[CTRL_DOWN];
                    clr    = rx_data[CTRL_CLR];
                end
                ADDR_PRESCALE: prescale_d = rx_data;
                ADDR_LED:      led_d      = rx_data[LED_W-1:0];
                ADDR_STATUS:   ovf_d      = ovf_q & ~rx_data[0];
                ADDR_SCRATCH:  scratch_d  = rx_data;
                default: ;
            endcase
        end
        if (ovf_pulse)
            ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            tx_q       <= '0;
            en_q       <= 1'b0;
            down_q     <= 1'b0;
            prescale_q <= '0;
            led_q      <= '0;
            scratch_q  <= '0;
            shadow_q   <= '0;
            ovf_q      <= 1'b0;
            cs_prev_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tx_q       <= tx_d;
            en_q       <= en_d;
            down_q     <= down_d;
            prescale_q <= prescale_d;
            led_q      <= led_d;
            scratch_q  <= scratch_d;
            shadow_q   <= shadow_d;
            ovf_q      <= ovf_d;
            cs_prev_q  <= cs_n;
        end
    end

    assign tx_data = tx_q;
    assign leds    = led_q;
endmodule
